// File: rtl/corelet_ctrl.sv
// corelet_ctrl: tile-pass sequencer driving the corelet strobes.
// Loads weights, streams activations, drains psums to pmem.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, n_act      pass request and activation vector count
//   w_base, a_base    xmem base addresses for weights / activations
//   p_base, simd_cfg  pmem base address, SIMD mode for the pass
//   ofifo_valid       output FIFO holds a word (fall-through)
//   xmem_en/addr      xmem read strobe and address
//   l0_wr, l0_rd      L0 FIFO write / read
//   load, execute     MAC array instructions
//   simd              latched SIMD mode for the pass
//   ofifo_rd, pmem_wr pop / psum write (combinational)
//   pmem_addr         psum write address
//   busy, done, err   status
module corelet_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int xmem_aw  = 11,
  parameter int pmem_aw  = 11,
  parameter int cnt_w    = 8,
  parameter int l0_depth = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_w-1:0]   n_act,
  input  logic [xmem_aw-1:0] w_base,
  input  logic [xmem_aw-1:0] a_base,
  input  logic [pmem_aw-1:0] p_base,
  input  logic               simd_cfg,
  input  logic               ofifo_valid,
  output logic               xmem_en,
  output logic [xmem_aw-1:0] xmem_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               load,
  output logic               execute,
  output logic               simd,
  output logic               ofifo_rd,
  output logic               pmem_wr,
  output logic [pmem_aw-1:0] pmem_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(row + col + l0_depth + 2);

  typedef enum logic [2:0] {
    IDLE, W_FILL, W_KICK, W_SETTLE,
    A_FILL, EXEC, DRAIN, DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      n_q;
  logic [CW-1:0]      pops_q;
  logic [CW-1:0]      pops_d;
  logic [xmem_aw-1:0] a_base_q;
  logic [xmem_aw-1:0] xmem_addr_q;
  logic [pmem_aw-1:0] pmem_addr_q;
  logic xmem_en_q, l0_wr_q, l0_rd_q;
  logic load_q, execute_q, simd_q;
  logic busy_q, done_q, err_q;
  logic n_ok, pop;

  assign n_ok = (n_act != '0) &&
                (int'(n_act) <= l0_depth);

  // Pops are capped at n_act so a stray word
  // can never overrun the pass.
  assign pop = ofifo_valid &&
               (state_q == EXEC ||
                state_q == DRAIN) &&
               (pops_q != n_q);
  assign pops_d = pops_q + CW'(pop);

  assign xmem_en   = xmem_en_q;
  assign xmem_addr = xmem_addr_q;
  assign l0_wr     = l0_wr_q;
  assign l0_rd     = l0_rd_q;
  assign load      = load_q;
  assign execute   = execute_q;
  assign simd      = simd_q;
  assign ofifo_rd  = pop;
  assign pmem_wr   = pop;
  assign pmem_addr = pmem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      pops_q      <= '0;
      a_base_q    <= '0;
      xmem_addr_q <= '0;
      pmem_addr_q <= '0;
      xmem_en_q   <= 1'b0;
      l0_wr_q     <= 1'b0;
      l0_rd_q     <= 1'b0;
      load_q      <= 1'b0;
      execute_q   <= 1'b0;
      simd_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      execute_q   <= 1'b0;
      l0_rd_q     <= 1'b0;
      xmem_en_q   <= 1'b0;
      xmem_addr_q <= '0;
      // L0 write lands one cycle after each read.
      l0_wr_q     <= xmem_en_q;
      cnt_q       <= cnt_q + CW'(1);
      pops_q      <= pops_d;
      if (pop)
        pmem_addr_q <= pmem_addr_q + pmem_aw'(1);
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start && n_ok) begin
            state_q     <= W_FILL;
            n_q         <= CW'(n_act);
            a_base_q    <= a_base;
            pmem_addr_q <= p_base;
            simd_q      <= simd_cfg;
            busy_q      <= 1'b1;
            pops_q      <= '0;
            xmem_en_q   <= 1'b1;
            xmem_addr_q <= w_base;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        W_FILL: begin
          if (cnt_q < CW'(row - 1)) begin
            xmem_en_q   <= 1'b1;
            xmem_addr_q <= xmem_addr_q
                           + xmem_aw'(1);
          end
          if (cnt_q == CW'(row)) begin
            state_q <= W_KICK;
            cnt_q   <= '0;
            l0_rd_q <= 1'b1;
            load_q  <= 1'b1;
          end
        end
        W_KICK: begin
          if (cnt_q == CW'(row - 1)) begin
            state_q <= W_SETTLE;
            cnt_q   <= '0;
          end else begin
            l0_rd_q <= 1'b1;
            load_q  <= 1'b1;
          end
        end
        W_SETTLE: begin
          if (cnt_q == CW'(row + col - 1)) begin
            state_q     <= A_FILL;
            cnt_q       <= '0;
            xmem_en_q   <= 1'b1;
            xmem_addr_q <= a_base_q;
          end
        end
        A_FILL: begin
          if (cnt_q < n_q - CW'(1)) begin
            xmem_en_q   <= 1'b1;
            xmem_addr_q <= xmem_addr_q
                           + xmem_aw'(1);
          end
          if (cnt_q == n_q) begin
            state_q   <= EXEC;
            cnt_q     <= '0;
            l0_rd_q   <= 1'b1;
            execute_q <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt_q == n_q - CW'(1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            l0_rd_q   <= 1'b1;
            execute_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (pops_d == n_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          simd_q      <= 1'b0;
          pmem_addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized bench for corelet_ctrl.
// Expected strobes come from a pass timeline model.
module tb_corelet_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int XAW  = 11;
  localparam int PAW  = 11;
  localparam int CNTW = 8;
  localparam int L0D  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [CNTW-1:0] n_act;
  logic [XAW-1:0]  w_base;
  logic [XAW-1:0]  a_base;
  logic [PAW-1:0]  p_base;
  logic            simd_cfg;
  logic            ofifo_valid;
  logic            xmem_en;
  logic [XAW-1:0]  xmem_addr;
  logic            l0_wr;
  logic            l0_rd;
  logic            load;
  logic            execute;
  logic            simd;
  logic            ofifo_rd;
  logic            pmem_wr;
  logic [PAW-1:0]  pmem_addr;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  corelet_ctrl #(
    .row(ROW), .col(COL),
    .xmem_aw(XAW), .pmem_aw(PAW),
    .cnt_w(CNTW), .l0_depth(L0D)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .n_act(n_act),
    .w_base(w_base), .a_base(a_base),
    .p_base(p_base), .simd_cfg(simd_cfg),
    .ofifo_valid(ofifo_valid),
    .xmem_en(xmem_en), .xmem_addr(xmem_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd),
    .load(load), .execute(execute),
    .simd(simd), .ofifo_rd(ofifo_rd),
    .pmem_wr(pmem_wr), .pmem_addr(pmem_addr),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  // Addresses only matter while their strobe is up.
  function automatic logic [63:0] obs();
    return {31'b0, xmem_en,
            xmem_en ? xmem_addr : 11'h0,
            l0_wr, l0_rd, load, execute, simd,
            ofifo_rd, pmem_wr,
            pmem_wr ? pmem_addr : 11'h0,
            busy, done, err};
  endfunction

  function automatic logic [63:0] pk(
    input logic xe, input logic [10:0] xa,
    input logic wr, input logic rd,
    input logic ld, input logic ex,
    input logic sm, input logic pp,
    input logic [10:0] pa, input logic bz,
    input logic dn, input logic er);
    return {31'b0, xe, xe ? xa : 11'h0,
            wr, rd, ld, ex, sm, pp, pp,
            pp ? pa : 11'h0, bz, dn, er};
  endfunction

  task automatic reject(input int n);
    @(negedge clk);
    start = 1'b1;
    n_act = CNTW'(n);
    #1 chk("rej_idle", obs(), 64'h0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("rej_err", obs(),
           pk(0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 1));
    @(negedge clk);
    #1 chk("rej_after", obs(), 64'h0);
  endtask

  // mode 0: random valid, 1: toggle from EXEC,
  // 2: valid only in DRAIN.
  // rst_off >= 0 resets in EXEC cycle rst_off+1.
  task automatic run_pass(
    input int n, input logic [10:0] wb,
    input logic [10:0] ab, input logic [10:0] pb,
    input logic cfg, input int mode,
    input int rst_off, input int pid);
    int t0, e0, pops, tp;
    logic v, p, kick, ex, fin;
    logic xe, wr;
    logic [10:0] xa;
    string tag;
    @(negedge clk);
    start = 1'b1;
    n_act = CNTW'(n);
    w_base = wb;
    a_base = ab;
    p_base = pb;
    simd_cfg = cfg;
    ofifo_valid = 1'b0;
    #1 chk("acc", obs(), 64'h0);
    t0 = 3 * ROW + COL + 2;
    e0 = t0 + n + 1;
    pops = 0;
    tp = -1;
    fin = 1'b0;
    for (int t = 1; t < 600 && !fin; t++) begin
      @(negedge clk);
      tag = $sformatf("p%0d_t%0d", pid, t);
      n_act = CNTW'($urandom);
      w_base = 11'($urandom);
      a_base = 11'($urandom);
      p_base = 11'($urandom);
      simd_cfg = 1'($urandom);
      start = (tp < 0 || t == tp + 1) &&
              ($urandom_range(7) == 0);
      if (t == ROW + 3) begin
        start = 1'b1;
        n_act = 8'd5;
      end
      if (tp >= 0 && t == tp + 2) begin
        start = 1'b0;
        ofifo_valid = 1'($urandom);
        #1 chk({tag, "_idle"}, obs(), 64'h0);
        fin = 1'b1;
      end else begin
        if (mode == 0)
          v = 1'($urandom);
        else if (mode == 1)
          v = (t >= e0) && ((t - e0) % 2 == 0);
        else
          v = (t >= e0 + n);
        if (t >= e0 && t < e0 + n &&
            pops == n - 1)
          v = 1'b0;
        ofifo_valid = v;
        #1;
        p = v && t >= e0 && pops < n;
        kick = t >= ROW + 2 && t <= 2 * ROW + 1;
        ex = t >= e0 && t < e0 + n;
        xe = 1'b0;
        xa = 11'h0;
        if (t >= 1 && t <= ROW) begin
          xe = 1'b1;
          xa = wb + 11'(t - 1);
        end
        if (t >= t0 && t < t0 + n) begin
          xe = 1'b1;
          xa = ab + 11'(t - t0);
        end
        wr = (t >= 2 && t <= ROW + 1) ||
             (t > t0 && t <= t0 + n);
        chk(tag, obs(),
            pk(xe, xa, wr, kick || ex, kick,
               ex, cfg && (tp < 0 ||
                           t == tp + 1),
               p, pb + 11'(pops), tp < 0,
               tp >= 0 && t == tp + 1, 1'b0));
        if (p) begin
          pops++;
          if (pops == n) tp = t;
        end
        if (rst_off >= 0 && t == e0 + rst_off) begin
          reset = 1'b1;
          @(negedge clk);
          start = 1'b0;
          ofifo_valid = 1'b1;
          #1 chk({tag, "_rst"}, obs(), 64'h0);
          reset = 1'b0;
          ofifo_valid = 1'b0;
          return;
        end
      end
    end
    if (!fin) chk("timeout", 64'h0, 64'h1);
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n_act = '0;
    w_base = '0;
    a_base = '0;
    p_base = '0;
    simd_cfg = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    ofifo_valid = 1'b1;
    #1 chk("reset", obs(), 64'h0);
    reset = 1'b0;
    ofifo_valid = 1'b0;
    @(negedge clk);
    #1 chk("post_reset", obs(), 64'h0);

    reject(0);
    reject(65);
    run_pass(4, 11'd0, 11'd16, 11'd100,
             1'b1, 2, -1, 0);
    run_pass(3, 11'd40, 11'd50, 11'd7,
             1'b0, 1, -1, 1);
    run_pass(4, 11'd2040, 11'd2045, 11'd2046,
             1'b1, 0, -1, 2);
    run_pass(5, 11'd1, 11'd9, 11'd300,
             1'b1, 0, 1, 3);
    run_pass(5, 11'd3, 11'd30, 11'd500,
             1'b0, 0, -1, 4);
    run_pass(1, 11'd5, 11'd6, 11'd7,
             1'b1, 0, -1, 5);
    run_pass(64, 11'd2000, 11'd2020, 11'd2040,
             1'b1, 0, -1, 6);
    for (int i = 0; i < 8; i++) begin
      run_pass($urandom_range(64, 1),
               11'($urandom), 11'($urandom),
               11'($urandom), 1'($urandom),
               $urandom_range(2), -1, 10 + i);
      if ($urandom_range(1) == 1)
        reject($urandom_range(255, 65));
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
